// File: rtl/fakeram_pkg.sv
// Shared types and constants for the 1R1W fake RAM model.
// Holds the sequencer state encoding and the legal read-latency range.
package fakeram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } fakeram_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Address width never collapses to zero, even for tiny arrays.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fakeram_init_seq.sv
// Post-reset zero-fill sequencer: walks every word address once, then
// parks in READY so the array accepts normal requests.
module fakeram_init_seq
    import fakeram_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int AW            = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    output logic [AW-1:0] init_addr,
    output logic          init_we
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    fakeram_state_t state;
    logic [AW-1:0]  count;

    // The sweep takes exactly DEPTH cycles; the last word is cleared on the
    // same edge that hands control over to READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (INIT_ON_RESET != 0) ? INIT : READY;
            count <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (count == LAST_ADDR) begin
                        state <= READY;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    assign init_busy = (state == INIT);
    assign init_we   = (state == INIT);
    assign init_addr = count;

endmodule

// File: rtl/fakeram_1r1w_param.sv
// Parameterised one-read/one-write behavioural RAM with bit-masked writes,
// write-first same-address forwarding, 1- or 2-cycle read pipeline.
module fakeram_1r1w_param
    import fakeram_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int DEPTH         = 256,
    parameter int RD_LAT        = 1,
    parameter int INIT_ON_RESET = 1,
    localparam int AW           = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic             init_busy,
    output logic             addr_err
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("fakeram_1r1w_param: RD_LAT must be 1 or 2");
    end
    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
        $error("fakeram_1r1w_param: WIDTH must be in 1..256");
    end
    if (DEPTH < 2 || DEPTH > 4096) begin : g_bad_depth
        $error("fakeram_1r1w_param: DEPTH must be in 2..4096");
    end

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    init_addr;
    logic             init_we;
    logic             rd_ok;
    logic             wr_ok;
    logic             rd_in_range;
    logic             wr_in_range;
    logic [WIDTH-1:0] rd_word;

    logic             pipe_valid [RD_LAT];
    logic [WIDTH-1:0] pipe_data  [RD_LAT];

    fakeram_init_seq #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_init_seq (
        .clk      (clk),
        .rst      (rst),
        .init_busy(init_busy),
        .init_addr(init_addr),
        .init_we  (init_we)
    );

    assign rd_ok       = rd_en && !init_busy && !rst;
    assign wr_ok       = wr_en && !init_busy && !rst;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);

    // Out-of-range reads return zero; a same-edge write to the read address
    // is merged in so the reader sees write-first data.
    always_comb begin
        rd_word = '0;
        if (rd_ok && rd_in_range) begin
            rd_word = mem[rd_addr];
            if (wr_ok && wr_in_range && (wr_addr == rd_addr)) begin
                rd_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
            end
        end
    end

    // The array is never reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= '0;
        end else if (wr_ok && wr_in_range) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Read data is captured at the request edge and then only shifted, so
    // later writes cannot disturb a read already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
            end
            addr_err <= 1'b0;
        end else begin
            pipe_valid[0] <= rd_ok;
            if (rd_ok) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
            addr_err <= (rd_ok && !rd_in_range) || (wr_ok && !wr_in_range);
        end
    end

    assign rd_valid = pipe_valid[RD_LAT-1];
    assign rd_data  = pipe_data[RD_LAT-1];

endmodule

// File: doc/fakeram_1r1w_param.md
FAKERAM_1R1W_PARAM -- requirements
Module: fakeram_1r1w_param

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data bits per word (1..256).
REQ-002 SHALL have parameter DEPTH, default 256, words stored (2..4096, power of two not required).
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (1 or 2 only; other values fail elaboration).
REQ-004 SHALL have parameter INIT_ON_RESET, default 1, zero-fill array after reset when 1.
REQ-005 SHALL derive AW = max(1, clog2(DEPTH)) for address width; not overridable.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rd_en  input  1  read request, active-high, sampled at clk edge.
REQ-009 SHALL have port rd_addr  input  AW  read word address.
REQ-010 SHALL have port rd_data  output  WIDTH  registered read data.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data carries a new read result.
REQ-012 SHALL have port wr_en  input  1  write request, active-high.
REQ-013 SHALL have port wr_addr  input  AW  write word address.
REQ-014 SHALL have port wr_data  input  WIDTH  write data.
REQ-015 SHALL have port wr_mask  input  WIDTH  per-bit write enable, 1 = bit written.
REQ-016 SHALL have port init_busy  output  1  high while zero-fill in progress; requests ignored.
REQ-017 SHALL have port addr_err  output  1  registered one-cycle pulse on any accepted request with address >= DEPTH.

Function
REQ-018 SHALL implement FSM states INIT and READY; INIT_ON_RESET=1 resets to INIT, 0 resets to READY.
REQ-019 In INIT SHALL write all-zero to one address per cycle, 0 up to DEPTH-1, then enter READY; INIT lasts exactly DEPTH cycles after rst deasserts.
REQ-020 init_busy SHALL equal (state == INIT); rd_en and wr_en SHALL be ignored (no write, no rd_valid) while init_busy=1.
REQ-021 In READY, wr_en=1 with wr_addr<DEPTH SHALL update mem[wr_addr] bit i to wr_data[i] only where wr_mask[i]=1, at the same edge.
REQ-022 In READY, rd_en=1 at edge N SHALL produce rd_data and rd_valid=1 at edge N+RD_LAT; rd_valid low otherwise.
REQ-023 Read and write to the same valid address at the same edge SHALL return write-first data: bit i = wr_mask[i] ? wr_data[i] : old bit i.
REQ-024 With RD_LAT=2, a write at edge N+1 to the address read at edge N SHALL NOT affect the read result (data captured at N).
REQ-025 Read with rd_addr>=DEPTH SHALL return all-zero with rd_valid=1 and pulse addr_err; write with wr_addr>=DEPTH SHALL be dropped and pulse addr_err.
REQ-026 rd_data SHALL hold its last value when no read completes; a new read SHALL be accepted every cycle (full throughput).
REQ-027 With INIT_ON_RESET=0, array contents after reset SHALL be unspecified (X in simulation); reads still pipeline normally.

Reset
REQ-028 rst=1 SHALL immediately force rd_data=0, rd_valid=0, addr_err=0, pipeline stages cleared, init counter=0, init_busy=INIT_ON_RESET.
REQ-029 Array contents SHALL NOT be reset directly; only the INIT sweep clears them.
REQ-030 rst asserted mid-INIT or mid-read SHALL discard in-flight reads and restart INIT from address 0.

Structure
REQ-031 Shared package fakeram_pkg SHALL hold the FSM state typedef (INIT, READY) and constants RD_LAT_MIN=1, RD_LAT_MAX=2.
REQ-032 Zero-fill counter and FSM SHALL be sub-module fakeram_init_seq (outputs init_busy, init_addr, init_we); array and read pipeline stay in the top.

Verification (WIDTH=64, DEPTH=256 unless noted)
REQ-033 Release rst, INIT_ON_RESET=1 -> init_busy high exactly 256 cycles; then read addr 0x00 and 0xFF -> 0x0.
REQ-034 Write 0xDEADBEEF_CAFEF00D mask all-ones to 0x10, then write 0xFFFFFFFF_FFFFFFFF mask 0x00000000_0000FFFF -> read 0x10 returns 0xDEADBEEF_CAFEFFFF.
REQ-035 Same-edge read+write addr 0x20, old 0x0, data 0xAAAA..AA mask 0xFF00..00 -> rd_data 0xAA00_0000_0000_0000 after RD_LAT.
REQ-036 RD_LAT=2, back-to-back reads of 0x01,0x02,0x03 -> rd_valid high 3 consecutive cycles starting 2 cycles after first, data in order.
REQ-037 DEPTH=200: write to 0xC8 -> addr_err pulse, no array change; read 0xC8 -> rd_data 0, rd_valid 1, addr_err pulse.
REQ-038 Assert rst at INIT cycle 100 for 1 cycle -> init_busy stays high, INIT completes 256 cycles after second release; pending rd_valid never asserted.
